matmul_seq_ctrl: RTL and testbench



---
 rtl/matmul_seq_ctrl.sv | 106 ++++++++++
 tb/tb_matmul_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl.sv
// Sequential 4x4 unsigned matrix multiply controller: streams in A then B,
// computes Y = A x B on one shared MAC (one product per cycle), streams Y out.
module matmul_seq_ctrl #(
  parameter int DW = 4,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [OW-1:0] out_data_o,
  output logic          out_last_o,
  input  logic          out_ready_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t          state_q;
  logic [4:0]      ld_idx_q;
  logic [5:0]      cnt_q;
  logic [3:0]      out_idx_q;
  logic [OW-1:0]   acc_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic            busy_q;
  logic [DW-1:0]   a_q [16];
  logic [DW-1:0]   b_q [16];
  logic [OW-1:0]   y_q [16];

  // cnt_q packs the loop counters as {i, j, k}, k innermost.
  logic [1:0]      i_w, j_w, k_w;
  logic [2*DW-1:0] prod_w;
  logic [OW-1:0]   sum_w;

  assign i_w    = cnt_q[5:4];
  assign j_w    = cnt_q[3:2];
  assign k_w    = cnt_q[1:0];
  assign prod_w = {{DW{1'b0}}, a_q[{i_w, k_w}]} * {{DW{1'b0}}, b_q[{k_w, j_w}]};
  assign sum_w  = ((k_w == 2'd0) ? '0 : acc_q) + {{(OW-2*DW){1'b0}}, prod_w};

  // in_ready is masked by rst so it reads 0 during reset and 1 the cycle after.
  assign in_ready_o  = (state_q == LOAD) && !rst;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign out_data_o  = out_valid_q ? y_q[out_idx_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      ld_idx_q    <= '0;
      cnt_q       <= '0;
      out_idx_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int n = 0; n < 16; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        y_q[n] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid_i) begin
            if (ld_idx_q[4]) b_q[ld_idx_q[3:0]] <= in_data_i;
            else             a_q[ld_idx_q[3:0]] <= in_data_i;
            ld_idx_q <= ld_idx_q + 5'd1;
            if (ld_idx_q == 5'd31) begin
              state_q <= COMPUTE;
              busy_q  <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          acc_q <= sum_w;
          cnt_q <= cnt_q + 6'd1;
          if (k_w == 2'd3) y_q[{i_w, j_w}] <= sum_w;
          if (cnt_q == 6'h3F) begin
            state_q     <= OUTPUT;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        OUTPUT: begin
          if (out_ready_i) begin
            out_idx_q  <= out_idx_q + 4'd1;
            out_last_q <= (out_idx_q == 4'd14);
            if (out_idx_q == 4'd15) begin
              state_q     <= LOAD;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: loads push expected results into a
// queue, a negedge monitor pops and compares on each output handshake.
module tb_matmul_seq_ctrl;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   last_in_edge = 0;
  int   first_in_edge = 0;
  int   last_out_edge = 0;
  int   beats = 0;
  int   pushed = 0;
  bit   rnd_ready = 0;
  bit   stall_q = 0;
  logic [15:0] hold_d;
  logic        hold_l;
  exp_t exp_q[$];
  int   ma[16];
  int   mb[16];

  matmul_seq_ctrl #(.DW(4), .OW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_ready_i(out_ready),
    .busy_o     (busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort(input string name);
    nerr++;
    $display("FAIL %s: timeout at cycle %0d", name, cyc);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1);
  endtask

  // Monitor: stability while stalled, then pop/compare on each handshake.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_q = 0;
    end else begin
      if (stall_q && out_valid) begin
        chk("stall_data", out_data, hold_d);
        chk("stall_last", out_last, hold_l);
      end
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("y_data", out_data, e.d);
          chk("y_last", out_last, e.last);
        end
        if (out_last) last_out_edge = cyc + 1;
      end
      stall_q = out_valid && !out_ready;
      hold_d  = out_data;
      hold_l  = out_last;
    end
  end

  task automatic send(input logic [3:0] d);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (n > 300) abort("send");
    end
    last_in_edge = cyc;
  endtask

  // Loads ma then mb; expected results come from a direct triple-loop product.
  task automatic load_pair(input bit push);
    if (push) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          int s;
          exp_t e;
          s = 0;
          for (int k = 0; k < 4; k++) s += ma[r*4+k] * mb[k*4+c];
          e.d = 16'(s);
          e.last = (r == 3 && c == 3);
          exp_q.push_back(e);
          pushed++;
        end
    end
    for (int e = 0; e < 16; e++) begin
      send(4'(ma[e]));
      if (e == 0) first_in_edge = last_in_edge;
    end
    for (int e = 0; e < 16; e++) send(4'(mb[e]));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    abort("watchdog");
  end

  initial begin
    int n;
    int prev_last;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Identity: A = I, B[r][c] = r*4+c -> outputs 0..15.
    for (int e = 0; e < 16; e++) begin
      ma[e] = (e / 4 == e % 4) ? 1 : 0;
      mb[e] = e;
    end
    load_pair(1);
    in_valid = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_after_load", busy, 1);
      if (out_valid || n > 200) break;
    end
    chk("first_valid_latency", n, 65);
    drain();

    // Maximum values: all 15 -> 900 everywhere.
    for (int e = 0; e < 16; e++) begin
      ma[e] = 15;
      mb[e] = 15;
    end
    load_pair(1);
    in_valid = 1'b0;
    drain();

    // Backpressure with A[r][c] = r+c, B = A.
    for (int e = 0; e < 16; e++) begin
      ma[e] = e / 4 + e % 4;
      mb[e] = ma[e];
    end
    rnd_ready = 1;
    load_pair(1);
    in_valid = 1'b0;
    drain();
    rnd_ready = 0;
    @(posedge clk);
    #1;

    // Garbage on the input throughout COMPUTE and OUTPUT.
    for (int e = 0; e < 16; e++) begin
      ma[e] = e % 4;
      mb[e] = (e / 4) + 1;
    end
    load_pair(1);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (!busy) break;
      chk("busy_in_ready", in_ready, 0);
      if (out_valid && out_ready && out_last) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = 4'($urandom_range(0, 15));
      end
    end
    chk("garbage_loop_end", busy, 0);
    in_valid = 1'b0;
    drain();
    for (int e = 0; e < 16; e++) begin
      ma[e] = 15 - e;
      mb[e] = (e % 5 == 0) ? 1 : 0;
    end
    load_pair(1);
    in_valid = 1'b0;
    drain();

    // Reset during compute cycle 30 discards the pair.
    for (int e = 0; e < 16; e++) begin
      ma[e] = 9;
      mb[e] = 9;
    end
    load_pair(0);
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    for (int e = 0; e < 16; e++) begin
      ma[e] = (e / 4 == e % 4) ? 1 : 0;
      mb[e] = 7;
    end
    load_pair(1);
    in_valid = 1'b0;
    drain();

    // Back-to-back pairs with in_valid and out_ready held high.
    for (int e = 0; e < 16; e++) begin
      ma[e] = e % 4;
      mb[e] = (e / 4 == e % 4) ? 1 : 0;
    end
    load_pair(1);
    prev_last = last_in_edge;
    for (int e = 0; e < 16; e++) begin
      ma[e] = 2;
      mb[e] = e / 4;
    end
    load_pair(1);
    in_valid = 1'b0;
    chk("b2b_gap", first_in_edge - prev_last, 81);
    chk("b2b_after_last", first_in_edge, last_out_edge + 1);
    drain();

    chk("total_beats", beats, pushed);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
